// File: rtl/mux_16_if.sv
// rtl/mux_16_if.sv - select/operand/result bundle for the 16:1 multiplexer
interface mux_16_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       sel_i;
  logic [WIDTH-1:0] in0_i;
  logic [WIDTH-1:0] in1_i;
  logic [WIDTH-1:0] in2_i;
  logic [WIDTH-1:0] in3_i;
  logic [WIDTH-1:0] in4_i;
  logic [WIDTH-1:0] in5_i;
  logic [WIDTH-1:0] in6_i;
  logic [WIDTH-1:0] in7_i;
  logic [WIDTH-1:0] in8_i;
  logic [WIDTH-1:0] in9_i;
  logic [WIDTH-1:0] in10_i;
  logic [WIDTH-1:0] in11_i;
  logic [WIDTH-1:0] in12_i;
  logic [WIDTH-1:0] in13_i;
  logic [WIDTH-1:0] in14_i;
  logic [WIDTH-1:0] in15_i;
  logic             en_i;
  logic [WIDTH-1:0] out_o;
  logic [WIDTH-1:0] out_q_o;

  // Producer side: drives select, operands and load enable
  modport master (
    output sel_i, en_i,
    output in0_i, in1_i, in2_i, in3_i, in4_i, in5_i, in6_i, in7_i,
    output in8_i, in9_i, in10_i, in11_i, in12_i, in13_i, in14_i, in15_i,
    input  out_o, out_q_o
  );

  // Multiplexer side: consumes operands, produces both results
  modport slave (
    input  sel_i, en_i,
    input  in0_i, in1_i, in2_i, in3_i, in4_i, in5_i, in6_i, in7_i,
    input  in8_i, in9_i, in10_i, in11_i, in12_i, in13_i, in14_i, in15_i,
    output out_o, out_q_o
  );
endinterface

// File: rtl/mux_16.sv
// rtl/mux_16.sv - 16:1 WIDTH-bit multiplexer with combinational and registered results
module mux_16 #(
  parameter int WIDTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  mux_16_if.slave  bus
);

  // Operands gathered into an array so the select is a plain index; an X/Z
  // select then yields an all-X result in simulation.
  logic [WIDTH-1:0] ops [16];

  assign ops[0]  = bus.in0_i;
  assign ops[1]  = bus.in1_i;
  assign ops[2]  = bus.in2_i;
  assign ops[3]  = bus.in3_i;
  assign ops[4]  = bus.in4_i;
  assign ops[5]  = bus.in5_i;
  assign ops[6]  = bus.in6_i;
  assign ops[7]  = bus.in7_i;
  assign ops[8]  = bus.in8_i;
  assign ops[9]  = bus.in9_i;
  assign ops[10] = bus.in10_i;
  assign ops[11] = bus.in11_i;
  assign ops[12] = bus.in12_i;
  assign ops[13] = bus.in13_i;
  assign ops[14] = bus.in14_i;
  assign ops[15] = bus.in15_i;

  // Zero-latency result, independent of clock and reset
  assign bus.out_o = ops[bus.sel_i];

  // Registered copy: cleared asynchronously, loads the live result when enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.out_q_o <= '0;
    end else if (bus.en_i) begin
      bus.out_q_o <= bus.out_o;
    end
  end

endmodule

// File: tb/tb_mux_16.sv
// tb/tb_mux_16.sv - directed self-checking bench for mux_16
module tb_mux_16;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mux_16_if #(.WIDTH(8))  b8 ();
  mux_16_if #(.WIDTH(32)) b32 ();

  mux_16 #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(b8));
  mux_16 #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set8(input int n, input logic [7:0] v);
    case (n)
      0: b8.in0_i = v;   1: b8.in1_i = v;   2: b8.in2_i = v;   3: b8.in3_i = v;
      4: b8.in4_i = v;   5: b8.in5_i = v;   6: b8.in6_i = v;   7: b8.in7_i = v;
      8: b8.in8_i = v;   9: b8.in9_i = v;   10: b8.in10_i = v; 11: b8.in11_i = v;
      12: b8.in12_i = v; 13: b8.in13_i = v; 14: b8.in14_i = v; default: b8.in15_i = v;
    endcase
  endtask

  task automatic set32(input int n, input logic [31:0] v);
    case (n)
      0: b32.in0_i = v;   1: b32.in1_i = v;   2: b32.in2_i = v;   3: b32.in3_i = v;
      4: b32.in4_i = v;   5: b32.in5_i = v;   6: b32.in6_i = v;   7: b32.in7_i = v;
      8: b32.in8_i = v;   9: b32.in9_i = v;   10: b32.in10_i = v; 11: b32.in11_i = v;
      12: b32.in12_i = v; 13: b32.in13_i = v; 14: b32.in14_i = v; default: b32.in15_i = v;
    endcase
  endtask

  initial begin
    logic [127:0] blk;
    vectors = 0;
    miscompares = 0;

    // reset asserted, operands in_n = 8'h10 + n
    rst_n = 1'b0;
    b8.en_i = 1'b0;
    b8.sel_i = 4'd0;
    b32.en_i = 1'b0;
    b32.sel_i = 4'd0;
    for (int n = 0; n < 16; n++) begin
      set8(n, 8'(8'h10 + n));
      set32(n, 32'h0);
    end
    #1;
    check("reset_q8", 32'(b8.out_q_o), 32'h0);
    check("reset_q32", b32.out_q_o, 32'h0);

    // exhaustive select, valid while reset is held
    for (int s = 0; s < 16; s++) begin
      b8.sel_i = 4'(s);
      #1;
      check($sformatf("sweep_sel%0d", s), 32'(b8.out_o), 32'(8'h10 + s));
    end

    // release reset away from the rising edge
    @(negedge clk);
    rst_n = 1'b1;

    // data independence on sel 5
    for (int n = 0; n < 16; n++) set8(n, 8'hFF);
    b8.sel_i = 4'd5;
    set8(5, 8'hAA);
    #1;
    check("indep_aa", 32'(b8.out_o), 32'hAA);
    set8(5, 8'h55);
    #1;
    check("indep_55", 32'(b8.out_o), 32'h55);
    set8(4, 8'h00);
    set8(6, 8'h00);
    #1;
    check("indep_neighbours", 32'(b8.out_o), 32'h55);

    // register path: load C3 on sel 15
    @(negedge clk);
    b8.en_i = 1'b1;
    b8.sel_i = 4'd15;
    set8(15, 8'hC3);
    @(posedge clk);
    #1;
    check("reg_load_c3", 32'(b8.out_q_o), 32'hC3);

    // hold with enable low
    @(negedge clk);
    b8.en_i = 1'b0;
    set8(15, 8'h3C);
    @(posedge clk);
    #1;
    check("reg_hold_c3", 32'(b8.out_q_o), 32'hC3);
    check("comb_3c", 32'(b8.out_o), 32'h3C);

    // async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_q", 32'(b8.out_q_o), 32'h00);
    check("async_comb_kept", 32'(b8.out_o), 32'h3C);
    b8.en_i = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held_q", 32'(b8.out_q_o), 32'h00);

    // release with enable low: no load, then first enabled edge reloads
    @(negedge clk);
    rst_n = 1'b1;
    b8.en_i = 1'b0;
    set8(15, 8'h5A);
    @(posedge clk);
    #1;
    check("post_reset_no_en", 32'(b8.out_q_o), 32'h00);
    @(negedge clk);
    b8.en_i = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_reload", 32'(b8.out_q_o), 32'h5A);

    // select and selected input change in the same cycle
    @(negedge clk);
    b8.sel_i = 4'd3;
    set8(3, 8'h77);
    @(posedge clk);
    #1;
    check("simul_change_q", 32'(b8.out_q_o), 32'h77);

    // WIDTH = 32 instance
    @(negedge clk);
    b32.sel_i = 4'd9;
    set32(9, 32'hDEADBEEF);
    set32(8, 32'h12345678);
    b32.en_i = 1'b1;
    #1;
    check("w32_comb", b32.out_o, 32'hDEADBEEF);
    check("w32_q_before_edge", b32.out_q_o, 32'h0);
    @(posedge clk);
    #1;
    check("w32_q", b32.out_q_o, 32'hDEADBEEF);

    // cache byte-select from a 128-bit block
    blk = 128'h0F0E0D0C0B0A09080706050403020100;
    for (int n = 0; n < 16; n++) set8(n, blk[8*n +: 8]);
    b8.sel_i = 4'hA;
    #1;
    check("cache_byte_a", 32'(b8.out_o), 32'h0A);
    b8.sel_i = 4'hF;
    #1;
    check("cache_byte_f", 32'(b8.out_o), 32'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
